// File: rtl/multicycle_control_unit.sv
// ID-stage control unit: zero-latency opcode decode plus a step sequencer for
// the multi-cycle SWP and iterative MUL macro-ops, with stall/flush handling.
module multicycle_control_unit #(
  parameter  int OPCODE_W  = 6,
  parameter  int EXEC_W    = 4,
  parameter  int MUL_STEPS = 4,
  localparam int STEP_W    = ($clog2(MUL_STEPS) > 1) ? $clog2(MUL_STEPS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                stall,
  input  logic                flush,
  output logic [EXEC_W-1:0]   exec_cmd,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic                wb_en,
  output logic                is_imm,
  output logic                single_src,
  output logic [1:0]          branch_type,
  output logic [1:0]          swp_sel,
  output logic                is_swp,
  output logic                is_mul,
  output logic                freeze,
  output logic [STEP_W-1:0]   step,
  output logic                seq_done
);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_NOR  = OPCODE_W'(6'b000111);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SLA  = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_SRA  = OPCODE_W'(6'b001011);
  localparam logic [OPCODE_W-1:0] OP_SRL  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b100000);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b100001);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'b100100);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(6'b100101);
  localparam logic [OPCODE_W-1:0] OP_BEZ  = OPCODE_W'(6'b101000);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b101001);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6'b101010);
  localparam logic [OPCODE_W-1:0] OP_SWP  = OPCODE_W'(6'b111111);

  localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);
  localparam logic [STEP_W-1:0] LAST_SWP  = STEP_W'(1);
  localparam logic [STEP_W-1:0] LAST_MUL  = STEP_W'(MUL_STEPS - 1);

  logic [STEP_W-1:0]   step_r, step_nxt_s;
  logic [OPCODE_W-1:0] op_r, op_nxt_s, act_op_s, dec_op_s;
  logic                in_seq_s, last_s;
  logic [EXEC_W-1:0]   exec_s;
  logic                mem_r_s, mem_w_s, wb_s, imm_s, single_src_s;
  logic [1:0]          bt_s, swp_sel_s;
  logic                is_swp_s, is_mul_s, freeze_s, done_s;

  // Sequencer next state: opcode latch at step 0, step advance, stall/flush.
  always_comb begin
    act_op_s   = (step_r == STEP_ZERO) ? opcode : op_r;
    in_seq_s   = (step_r != STEP_ZERO) ||
                 (instr_valid && ((opcode == OP_SWP) || (opcode == OP_MUL)));
    last_s     = (act_op_s == OP_SWP) ? (step_r == LAST_SWP) : (step_r == LAST_MUL);
    step_nxt_s = step_r;
    op_nxt_s   = op_r;
    if (flush) begin
      step_nxt_s = STEP_ZERO;
    end else if (stall) begin
      step_nxt_s = step_r;
    end else if (in_seq_s) begin
      if (last_s) begin
        step_nxt_s = STEP_ZERO;
      end else begin
        step_nxt_s = step_r + STEP_W'(1);
        if (step_r == STEP_ZERO) begin
          op_nxt_s = opcode;
        end else begin
          op_nxt_s = op_r;
        end
      end
    end else begin
      step_nxt_s = STEP_ZERO;
    end
  end

  // Step counter and latched macro-op opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r <= STEP_ZERO;
      op_r   <= OP_NOP;
    end else begin
      step_r <= step_nxt_s;
      op_r   <= op_nxt_s;
    end
  end

  // Opcode decode; an invalid slot only becomes NOP when no sequence is running.
  always_comb begin
    dec_op_s     = ((step_r == STEP_ZERO) && !instr_valid) ? OP_NOP : act_op_s;
    exec_s       = EXEC_W'(4'b0000);
    mem_r_s      = 1'b0;
    mem_w_s      = 1'b0;
    wb_s         = 1'b0;
    imm_s        = 1'b0;
    single_src_s = 1'b0;
    bt_s         = 2'b00;
    swp_sel_s    = 2'b00;
    is_swp_s     = 1'b0;
    is_mul_s     = 1'b0;
    freeze_s     = 1'b0;
    done_s       = 1'b0;
    case (dec_op_s)
      OP_ADD:          wb_s = 1'b1;
      OP_SUB:          begin exec_s = EXEC_W'(4'b0010); wb_s = 1'b1; end
      OP_AND:          begin exec_s = EXEC_W'(4'b0100); wb_s = 1'b1; end
      OP_OR:           begin exec_s = EXEC_W'(4'b0101); wb_s = 1'b1; end
      OP_NOR:          begin exec_s = EXEC_W'(4'b0110); wb_s = 1'b1; end
      OP_XOR:          begin exec_s = EXEC_W'(4'b0111); wb_s = 1'b1; end
      OP_SLA, OP_SLL:  begin exec_s = EXEC_W'(4'b1000); wb_s = 1'b1; end
      OP_SRA:          begin exec_s = EXEC_W'(4'b1001); wb_s = 1'b1; end
      OP_SRL:          begin exec_s = EXEC_W'(4'b1010); wb_s = 1'b1; end
      OP_ADDI:         begin imm_s = 1'b1; wb_s = 1'b1; single_src_s = 1'b1; end
      OP_SUBI: begin
        exec_s = EXEC_W'(4'b0010); imm_s = 1'b1; wb_s = 1'b1; single_src_s = 1'b1;
      end
      OP_LD: begin
        imm_s = 1'b1; mem_r_s = 1'b1; wb_s = 1'b1; single_src_s = 1'b1;
      end
      OP_ST:           begin imm_s = 1'b1; mem_w_s = 1'b1; end
      OP_BEZ:          begin imm_s = 1'b1; bt_s = 2'b01; single_src_s = 1'b1; end
      OP_BNE:          begin imm_s = 1'b1; bt_s = 2'b10; end
      OP_JMP:          begin imm_s = 1'b1; bt_s = 2'b11; single_src_s = 1'b1; end
      OP_SWP: begin
        exec_s    = (step_r == STEP_ZERO) ? EXEC_W'(4'b1100) : EXEC_W'(4'b1101);
        swp_sel_s = (step_r == STEP_ZERO) ? 2'b01 : 2'b10;
        wb_s      = 1'b1;
        is_swp_s  = 1'b1;
        freeze_s  = (step_r == STEP_ZERO);
        done_s    = (step_r == LAST_SWP);
      end
      OP_MUL: begin
        exec_s   = (step_r == LAST_MUL) ? EXEC_W'(4'b1111) : EXEC_W'(4'b1110);
        is_mul_s = 1'b1;
        wb_s     = (step_r == LAST_MUL);
        freeze_s = (step_r != LAST_MUL);
        done_s   = (step_r == LAST_MUL);
      end
      default: exec_s = EXEC_W'(4'b0000);
    endcase
  end

  // Output gating: reset and flush both present a clean NOP to ID/EX.
  always_comb begin
    if (!rst_n || flush) begin
      exec_cmd    = EXEC_W'(4'b0000);
      mem_r_en    = 1'b0;
      mem_w_en    = 1'b0;
      wb_en       = 1'b0;
      is_imm      = 1'b0;
      single_src  = 1'b0;
      branch_type = 2'b00;
      swp_sel     = 2'b00;
      is_swp      = 1'b0;
      is_mul      = 1'b0;
      freeze      = 1'b0;
      step        = STEP_ZERO;
      seq_done    = 1'b0;
    end else begin
      exec_cmd    = exec_s;
      mem_r_en    = mem_r_s;
      mem_w_en    = mem_w_s;
      wb_en       = wb_s;
      is_imm      = imm_s;
      single_src  = single_src_s;
      branch_type = bt_s;
      swp_sel     = swp_sel_s;
      is_swp      = is_swp_s;
      is_mul      = is_mul_s;
      freeze      = freeze_s;
      step        = step_r;
      seq_done    = done_s;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit (MUL_STEPS = 4).
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] exec;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       imm;
    logic       ss;
    logic [1:0] bt;
    logic [1:0] swp;
    logic       is_swp;
    logic       is_mul;
    logic       frz;
    logic [1:0] step;
    logic       done;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       v;
    logic       st;
    logic       fl;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000001;
  logic       instr_valid = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] exec_cmd;
  logic       mem_r_en, mem_w_en, wb_en, is_imm, single_src;
  logic [1:0] branch_type, swp_sel;
  logic       is_swp, is_mul, freeze, seq_done;
  logic [1:0] step;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  outs_t act;

  multicycle_control_unit #(.OPCODE_W(6), .EXEC_W(4), .MUL_STEPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .exec_cmd(exec_cmd), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .wb_en(wb_en), .is_imm(is_imm), .single_src(single_src),
    .branch_type(branch_type), .swp_sel(swp_sel), .is_swp(is_swp), .is_mul(is_mul),
    .freeze(freeze), .step(step), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  assign act = {exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm, single_src,
                branch_type, swp_sel, is_swp, is_mul, freeze, step, seq_done};

  function automatic outs_t mk(logic [3:0] e, logic mr, logic mw, logic wb, logic im,
                               logic ss, logic [1:0] bt, logic [1:0] sw, logic isw,
                               logic imu, logic fz, logic [1:0] st, logic dn);
    return {e, mr, mw, wb, im, ss, bt, sw, isw, imu, fz, st, dn};
  endfunction

  task automatic add(logic [5:0] op, logic v, logic st, logic fl, outs_t e, string nm);
    vec_t t;
    t.op = op; t.v = v; t.st = st; t.fl = fl; t.exp = e; t.name = nm;
    vecs.push_back(t);
  endtask

  task automatic check(string nm, outs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  localparam logic [5:0] ADD = 6'b000001, SUB = 6'b000011, SRL = 6'b001100;
  localparam logic [5:0] LD = 6'b100100, ST = 6'b100101, BEZ = 6'b101000;
  localparam logic [5:0] BNE = 6'b101001, JMP = 6'b101010, ILL = 6'b010000;
  localparam logic [5:0] SWP = 6'b111111, MUL = 6'b001101, NOP = 6'b000000;
  localparam logic [5:0] ADDI = 6'b100000;

  initial begin
    outs_t zero, mul0;
    zero = mk(4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0);
    mul0 = mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd0, 0);

    // single-cycle decode
    add(ADD,  1, 0, 0, mk(4'h0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "add");
    add(LD,   1, 0, 0, mk(4'h0, 1, 0, 1, 1, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "ld");
    add(ST,   1, 0, 0, mk(4'h0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "st");
    add(SUB,  1, 0, 0, mk(4'h2, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "sub");
    add(BEZ,  1, 0, 0, mk(4'h0, 0, 0, 0, 1, 1, 2'd1, 2'd0, 0, 0, 0, 2'd0, 0), "bez");
    add(BNE,  1, 0, 0, mk(4'h0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 0, 0, 0, 2'd0, 0), "bne");
    add(JMP,  1, 0, 0, mk(4'h0, 0, 0, 0, 1, 1, 2'd3, 2'd0, 0, 0, 0, 2'd0, 0), "jmp");
    add(SRL,  1, 0, 0, mk(4'hA, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "srl");
    add(ADDI, 1, 0, 0, mk(4'h0, 0, 0, 1, 1, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "addi");
    add(ILL,  1, 0, 0, zero, "illegal_nop");
    add(ADD,  0, 0, 0, zero, "invalid_nop");
    add(MUL,  0, 0, 0, zero, "invalid_mul_nostart");
    // SWP two steps
    add(SWP,  1, 0, 0, mk(4'hC, 0, 0, 1, 0, 0, 2'd0, 2'd1, 1, 0, 1, 2'd0, 0), "swp_s0");
    add(SWP,  1, 0, 0, mk(4'hD, 0, 0, 1, 0, 0, 2'd0, 2'd2, 1, 0, 0, 2'd1, 1), "swp_s1");
    // MUL, opcode switched to ADD mid-sequence; ADD follows with no bubble
    add(MUL,  1, 0, 0, mul0, "mul_s0");
    add(MUL,  1, 0, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1, 0), "mul_s1");
    add(ADD,  1, 0, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd2, 0), "mul_s2");
    add(ADD,  1, 0, 0, mk(4'hF, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 1, 0, 2'd3, 1), "mul_s3");
    add(ADD,  1, 0, 0, mk(4'h0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "b2b_add");
    // MUL stalled two cycles at step 1; invalid slot mid-sequence is ignored
    add(MUL,  1, 0, 0, mul0, "mst_s0");
    add(MUL,  1, 1, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1, 0), "mst_s1_st");
    add(MUL,  1, 1, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1, 0), "mst_s1_st2");
    add(MUL,  1, 0, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1, 0), "mst_s1");
    add(NOP,  0, 0, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd2, 0), "mst_s2_inv");
    add(NOP,  1, 0, 0, mk(4'hF, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 1, 0, 2'd3, 1), "mst_s3");
    // SWP flushed on its second step
    add(SWP,  1, 0, 0, mk(4'hC, 0, 0, 1, 0, 0, 2'd0, 2'd1, 1, 0, 1, 2'd0, 0), "fswp_s0");
    add(SWP,  1, 0, 1, zero, "fswp_flush");
    add(SUB,  1, 0, 0, mk(4'h2, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "after_flush");
    // flush beats stall at step 0; sequence then runs normally
    add(MUL,  1, 1, 1, zero, "flush_stall");
    add(MUL,  1, 0, 0, mul0, "fm_s0");
    add(MUL,  1, 0, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1, 0), "fm_s1");
    add(MUL,  1, 0, 0, mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd2, 0), "fm_s2");
    add(MUL,  1, 0, 0, mk(4'hF, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 1, 0, 2'd3, 1), "fm_s3");

    // reset state: ADD valid on the input, reset held
    #3;
    check("reset_hold", zero);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      opcode = vecs[i].op; instr_valid = vecs[i].v;
      stall = vecs[i].st; flush = vecs[i].fl;
      #2;
      check(vecs[i].name, vecs[i].exp);
    end

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    opcode = MUL; instr_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    #2 check("rm_s0", mul0);
    @(negedge clk); #2;
    @(negedge clk); #2;
    check("rm_s2", mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd2, 0));
    #1 rst_n = 1'b0;
    #1 check("rm_async", zero);
    @(posedge clk); #1;
    check("rm_held", zero);
    @(negedge clk);
    rst_n = 1'b1;
    #2 check("rm_restart_s0", mul0);
    @(negedge clk); #2;
    check("rm_restart_s1", mk(4'hE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-issue decode control unit. It decodes the 6-bit opcode into execute, memory, writeback and branch controls, and sequences multi-cycle macro-ops through a registered step counter: SWP (2 steps) and iterative MUL (MUL_STEPS steps). While a macro-op is in flight it holds the fetch/decode stages with freeze. It also honours pipeline stall and flush. It sits in the ID stage between the instruction register and the ID/EX pipeline register.

Parameters:
OPCODE_W, 6, opcode width
EXEC_W, 4, exec_cmd width
MUL_STEPS, 4, cycles per MUL macro-op; legal range 2..16
STEP_W, derived localparam = max(1, clog2(MUL_STEPS)), step counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous, active-low
opcode  in  OPCODE_W  opcode of the instruction in ID
instr_valid  in  1  ID holds a real instruction; 0 is decoded as NOP
stall  in  1  hazard stall; holds the sequencer state
flush  in  1  branch-taken flush; aborts any sequence
exec_cmd  out  EXEC_W  ALU command
mem_r_en, mem_w_en, wb_en, is_imm, single_src  out  1 each  standard controls
branch_type  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP
swp_sel  out  2  00 none, 01 first swap half, 10 second swap half
is_swp  out  1  current step belongs to SWP
is_mul  out  1  current step belongs to MUL
freeze  out  1  hold PC and IF/ID register this cycle
step  out  STEP_W  current micro-step index
seq_done  out  1  one-cycle pulse on the last step of a macro-op

Behaviour:
- Outputs are combinational from (active opcode, step, instr_valid, flush). Decode latency is zero; the ID/EX register samples the outputs.
- Active opcode: equals the opcode input when step==0. While step!=0 it equals op_q, a register loaded at step 0 of a macro-op. Opcode changes mid-sequence are ignored.
- Single-cycle decode (opcode -> exec_cmd, other flags; all unlisted flags 0):
  - NOP 000000 -> 0000.
  - ADD 000001 -> 0000, wb. SUB 000011 -> 0010, wb. AND 000101 -> 0100, wb. OR 000110 -> 0101, wb.
  - NOR 000111 -> 0110, wb. XOR 001000 -> 0111, wb. SLA/SLL 001001/001010 -> 1000, wb. SRA 001011 -> 1001, wb. SRL 001100 -> 1010, wb.
  - ADDI 100000 -> 0000, imm, wb, single_src. SUBI 100001 -> 0010, imm, wb, single_src.
  - LD 100100 -> 0000, imm, mem_r, wb, single_src. ST 100101 -> 0000, imm, mem_w.
  - BEZ 101000 -> 0000, imm, bt=01, single_src. BNE 101001 -> 0000, imm, bt=10. JMP 101010 -> 0000, imm, bt=11, single_src.
  - Any other opcode -> NOP.
- SWP 111111 (2 steps):
  - step0: exec 1100, swp_sel 01, wb, is_swp, freeze=1.
  - step1: exec 1101, swp_sel 10, wb, is_swp, freeze=0, seq_done=1.
- MUL 001101 (MUL_STEPS steps):
  - steps 0..MUL_STEPS-2: exec 1110 (accumulate), is_mul, wb=0, freeze=1.
  - last step: exec 1111, is_mul, wb=1, freeze=0, seq_done=1.
- Step counter:
  - With a macro-op active, no stall and no flush, step increments each clock.
  - On the last step it returns to 0.
  - For single-cycle ops it stays 0.
- stall=1: step and op_q hold; outputs keep their decoded values; freeze still follows the step.
- flush=1 (priority over stall):
  - All outputs are forced to NOP that cycle, including freeze=0 and seq_done=0.
  - step<=0 on the next edge. A partially completed SWP/MUL never asserts its final wb.
- instr_valid=0 with step==0: decodes as NOP. With step!=0 the sequence continues regardless.
- Reset (async, rst_n low): step=0 and op_q=0 immediately. While reset is held all outputs are 0, including freeze. Reset mid-sequence aborts it, and the first post-reset cycle decodes the input opcode from step 0.
- Back-to-back macro-ops: after the last step, step==0, so the next opcode starts a new sequence on the following cycle with no bubble.

Test Plan:
- ADD (000001), then LD (100100), valid -> exec 0000/wb=1; then exec 0000, imm, mem_r, wb, single_src; freeze=0 and step=0 throughout.
- SWP held for 2 cycles -> cycle0 exec=1100, swp_sel=01, freeze=1, step=0; cycle1 exec=1101, swp_sel=10, freeze=0, seq_done=1; step returns to 0.
- MUL with MUL_STEPS=4, opcode input changed to ADD after cycle 1 -> exec 1110,1110,1110,1111; wb only on cycle 3; freeze 1,1,1,0; steps 0,1,2,3.
- MUL with stall=1 during step 1 for 2 cycles -> step stays 1, freeze=1, outputs unchanged; total sequence takes 6 cycles; single seq_done pulse.
- SWP with flush=1 at step1 -> that cycle all outputs 0, no seq_done; next cycle step=0 and the new opcode is decoded.
- rst_n pulled low mid-MUL (step=2), asynchronously between edges -> outputs and step go to 0 without waiting for a clock; after release, the sequence restarts from step 0.
